// File: rtl/exponent_unpack_pipe.sv
// rtl/exponent_unpack_pipe.sv - two-stage half/single/double sign and exponent unpacker
module exponent_unpack_pipe #(
    parameter int FP_W   = 64,
    parameter int FRAC_W = 52,
    parameter int EXP_W  = 12,
    parameter int SH_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   in_fp,
    input  logic [1:0]        in_fmt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              s,
    output logic [EXP_W-1:0]  e,
    output logic              e_z,
    output logic              e_inf,
    output logic              is_zero,
    output logic [SH_W-1:0]   norm_sh,
    output logic              fmt_err
);

    localparam logic [1:0] FMT_SINGLE = 2'b00;
    localparam logic [1:0] FMT_HALF   = 2'b10;

    // Highest set bit wins because later loop iterations overwrite earlier ones.
    function automatic logic [SH_W-1:0] clz(input logic [FRAC_W-1:0] f);
        logic [SH_W-1:0] c;
        c = '0;
        for (int i = 0; i < FRAC_W; i++) begin
            if (f[i]) c = SH_W'(FRAC_W - 1 - i);
        end
        return c;
    endfunction

    logic              v1, v2;
    logic              adv1, adv2;
    logic              s1;
    logic [10:0]       exp1;
    logic [FRAC_W-1:0] frac1;
    logic [1:0]        fmt1;

    logic [10:0]       in_exp;
    logic [FRAC_W-1:0] in_frac;

    assign adv2      = ~v2 | out_ready;
    assign adv1      = ~v1 | adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // Field extraction; the reserved encoding falls through to the double layout.
    always_comb begin
        in_exp  = '0;
        in_frac = '0;
        case (in_fmt)
            FMT_SINGLE: begin
                in_exp  = {3'b000, in_fp[FP_W-2 -: 8]};
                in_frac = {in_fp[FP_W-10 -: 23], {(FRAC_W-23){1'b0}}};
            end
            FMT_HALF: begin
                in_exp  = {6'b000000, in_fp[FP_W-2 -: 5]};
                in_frac = {in_fp[FP_W-7 -: 10], {(FRAC_W-10){1'b0}}};
            end
            default: begin
                in_exp  = in_fp[FP_W-2 -: 11];
                in_frac = in_fp[FP_W-13 -: FRAC_W];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            s1    <= 1'b0;
            exp1  <= '0;
            frac1 <= '0;
            fmt1  <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1    <= in_fp[FP_W-1];
                exp1  <= in_exp;
                frac1 <= in_frac;
                fmt1  <= in_fmt;
            end
        end
    end

    logic             c_ez, c_einf, c_fnz;
    logic [10:0]      c_eadj;
    logic [EXP_W-1:0] c_bias, c_ub, c_e;
    logic [SH_W-1:0]  c_sh;

    always_comb begin
        c_ez   = (exp1 == 11'd0);
        c_fnz  = |frac1;
        c_eadj = {exp1[10:1], exp1[0] | c_ez};
        c_einf = 1'b0;
        c_bias = EXP_W'(1023);
        case (fmt1)
            FMT_SINGLE: begin
                c_einf = (exp1[7:0] == 8'hFF);
                c_bias = EXP_W'(127);
            end
            FMT_HALF: begin
                c_einf = (exp1[4:0] == 5'h1F);
                c_bias = EXP_W'(15);
            end
            default: c_einf = (exp1 == 11'h7FF);
        endcase
        c_ub = EXP_W'(c_eadj) - c_bias;
        c_sh = (c_ez && c_fnz) ? clz(frac1) + SH_W'(1) : '0;
        c_e  = c_ub - EXP_W'(c_sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            s       <= 1'b0;
            e       <= '0;
            e_z     <= 1'b0;
            e_inf   <= 1'b0;
            is_zero <= 1'b0;
            norm_sh <= '0;
            fmt_err <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s       <= s1;
                e       <= c_e;
                e_z     <= c_ez;
                e_inf   <= c_einf;
                is_zero <= c_ez & ~c_fnz;
                norm_sh <= c_sh;
                fmt_err <= (fmt1 == 2'b11);
            end
        end
    end

endmodule

// File: tb/tb_exponent_unpack_pipe.sv
// tb/tb_exponent_unpack_pipe.sv - scoreboard bench for exponent_unpack_pipe
module tb_exponent_unpack_pipe;

    typedef struct packed {
        logic        s;
        logic [11:0] e;
        logic        ez;
        logic        einf;
        logic        iz;
        logic [5:0]  sh;
        logic        ferr;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_fp = '0;
    logic [1:0]  in_fmt = 2'b01;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        s;
    logic [11:0] e;
    logic        e_z, e_inf, is_zero, fmt_err;
    logic [5:0]  norm_sh;

    int checks = 0;
    int failures = 0;
    res_t exp_q[$];
    res_t held;
    logic prev_stall = 1'b0;
    res_t act;

    exponent_unpack_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fp(in_fp), .in_fmt(in_fmt), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .e(e), .e_z(e_z), .e_inf(e_inf), .is_zero(is_zero),
        .norm_sh(norm_sh), .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    assign act = '{s: s, e: e, ez: e_z, einf: e_inf, iz: is_zero, sh: norm_sh, ferr: fmt_err};

    function automatic res_t mk(logic s_, int e_, logic ez_, logic einf_, logic iz_, int sh_, logic ferr_);
        res_t r;
        r.s = s_; r.e = 12'(e_); r.ez = ez_; r.einf = einf_; r.iz = iz_; r.sh = 6'(sh_); r.ferr = ferr_;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: pops on every output transfer, and checks held outputs during stalls.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(act), 64'h0);
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %h expected none", act);
            end else begin
                check("result", 64'(act), 64'(exp_q.pop_front()));
            end
        end
        if (!rst && out_valid && !out_ready) begin
            if (prev_stall) check("stall_hold", 64'(act), 64'(held));
            held = act;
            prev_stall = 1'b1;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(logic [63:0] fp, logic [1:0] fmt, res_t x);
        int n;
        n = 0;
        in_fp = fp;
        in_fmt = fmt;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        exp_q.push_back(x);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        @(posedge clk);
        check("drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_data", 64'(act), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        send(64'h3FF0000000000000, 2'b01, mk(0, 0, 0, 0, 0, 0, 0));
        send(64'hFF80000000000000, 2'b00, mk(1, 128, 0, 1, 0, 0, 0));
        send(64'h0000000000000001, 2'b01, mk(0, -1074, 1, 0, 0, 52, 0));
        send(64'h0001000000000000, 2'b10, mk(0, -24, 1, 0, 0, 10, 0));
        send(64'h0000000000000000, 2'b01, mk(0, -1022, 1, 0, 1, 0, 0));
        send(64'h4000000000000000, 2'b11, mk(0, 1, 0, 0, 0, 0, 1));
        send(64'h4000000000000000, 2'b01, mk(0, 1, 0, 0, 0, 0, 0));
        send(64'h7C00000000000000, 2'b10, mk(0, 16, 0, 1, 0, 0, 0));
        send(64'h0000000100000000, 2'b00, mk(0, -149, 1, 0, 0, 23, 0));
        send(64'h7FF8000000000000, 2'b01, mk(0, 1024, 0, 1, 0, 0, 0));
        send(64'h8000000000000000, 2'b10, mk(1, -14, 1, 0, 1, 0, 0));
        drain();

        // Backpressure: two operands fill the pipe, then two more wait on in_ready.
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(64'h3FF0000000000000, 2'b01, mk(0, 0, 0, 0, 0, 0, 0));
        send(64'h4000000000000000, 2'b01, mk(0, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        fork
            begin
                send(64'h3C00000000000000, 2'b10, mk(0, 0, 0, 0, 0, 0, 0));
                send(64'h4000000000000000, 2'b00, mk(0, 1, 0, 0, 0, 0, 0));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset while stalled with two operands buffered: both must vanish.
        #1 out_ready = 1'b0;
        send(64'hBFF0000000000000, 2'b01, mk(1, 0, 0, 0, 0, 0, 0));
        send(64'h3F80000000000000, 2'b00, mk(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_stall_out_valid", 64'(out_valid), 64'd0);
        check("rst_stall_data", 64'(act), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_no_output", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
